// File: rtl/npc_pkg.sv
// Shared NPC core definitions: op classes, RV32I opcodes, immediate formats and
// the immediate generator used by the decode stage.
package npc_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      OP_LUI,
      OP_AUIPC,
      OP_JAL,
      OP_JALR,
      OP_BRANCH,
      OP_LOAD,
      OP_STORE,
      OP_OPIMM,
      OP_OP,
      OP_SYSTEM,
      OP_ILLEGAL
   } op_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
      logic [XLEN-1:0] imm;
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   imm = {ins[31:12], 12'b0};
         IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/gpr_file.sv
// General-purpose register file: two read ports with write-forwarding, one write port.
// IDU_RV32E_EN selects a 16-entry file and ignores writes to x16..x31.
module gpr_file
   import npc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data
);

`ifdef IDU_RV32E_EN
   localparam int unsigned IDX_W = 4;
`else
   localparam int unsigned IDX_W = 5;
`endif
   localparam int unsigned NREG = 1 << IDX_W;

   logic [XLEN-1:0] regs [NREG];
   logic            wr_ok;

`ifdef IDU_RV32E_EN
   assign wr_ok = wb_en && (wb_rd != 5'd0) && !wb_rd[4];
`else
   assign wr_ok = wb_en && (wb_rd != 5'd0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[wb_rd[IDX_W-1:0]] <= wb_data;
      end
   end

   // x0 and out-of-range indices read zero; a same-cycle write wins over the array
   function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
      logic [XLEN-1:0] d;
      d = '0;
`ifdef IDU_RV32E_EN
      if (addr[4]) begin
         d = '0;
      end else
`endif
      if (addr == 5'd0) begin
         d = '0;
      end else if (wr_ok && (wb_rd == addr)) begin
         d = wb_data;
      end else begin
         d = regs[addr[IDX_W-1:0]];
      end
      return d;
   endfunction

   always_comb begin
      rs1_data = read_port(rs1_addr);
      rs2_data = read_port(rs2_addr);
   end

endmodule

// File: rtl/idu_stage.sv
// RV32I decode stage: valid/ready in from fetch, registered decode packet out to execute.
// IDU_RV32E_EN: 16-entry register file and register-index legality check.
module idu_stage
   import npc_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [31:0]      in_ins,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pc,
   output logic [3:0]       out_op,
   output logic [2:0]       out_funct3,
   output logic             out_funct7b5,
   output logic [4:0]       out_rd,
   output logic [31:0]      out_imm,
   output logic [31:0]      out_rs1_data,
   output logic [31:0]      out_rs2_data,
   output logic             out_illegal,
   input  logic             wb_en,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data
);

   typedef enum logic {
      S_IDLE,
      S_FULL
   } state_e;

   state_e          state_q, state_d;
   logic            capture;

   op_e             dec_op;
   imm_fmt_e        dec_fmt;
   logic            dec_illegal;
   logic [4:0]      rs1_idx, rs2_idx, rd_idx;
   logic [XLEN-1:0] rs1_rd_data, rs2_rd_data;
   op_e             out_op_q;

   assign rs1_idx = in_ins[19:15];
   assign rs2_idx = in_ins[24:20];
   assign rd_idx  = in_ins[11:7];

   gpr_file u_gpr (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_idx),
      .rs2_addr (rs2_idx),
      .rs1_data (rs1_rd_data),
      .rs2_data (rs2_rd_data),
      .wb_en    (wb_en),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data)
   );

   always_comb begin
      dec_op  = OP_ILLEGAL;
      dec_fmt = IMM_NONE;
      case (in_ins[6:0])
         OPC_LUI:    begin dec_op = OP_LUI;    dec_fmt = IMM_U;    end
         OPC_AUIPC:  begin dec_op = OP_AUIPC;  dec_fmt = IMM_U;    end
         OPC_JAL:    begin dec_op = OP_JAL;    dec_fmt = IMM_J;    end
         OPC_JALR:   begin dec_op = OP_JALR;   dec_fmt = IMM_I;    end
         OPC_BRANCH: begin dec_op = OP_BRANCH; dec_fmt = IMM_B;    end
         OPC_LOAD:   begin dec_op = OP_LOAD;   dec_fmt = IMM_I;    end
         OPC_STORE:  begin dec_op = OP_STORE;  dec_fmt = IMM_S;    end
         OPC_OPIMM:  begin dec_op = OP_OPIMM;  dec_fmt = IMM_I;    end
         OPC_OP:     begin dec_op = OP_OP;     dec_fmt = IMM_NONE; end
         OPC_SYSTEM: begin dec_op = OP_SYSTEM; dec_fmt = IMM_I;    end
         default:    begin dec_op = OP_ILLEGAL; dec_fmt = IMM_NONE; end
      endcase
`ifdef IDU_RV32E_EN
      dec_illegal = (dec_op == OP_ILLEGAL) || rs1_idx[4] || rs2_idx[4] || rd_idx[4];
`else
      dec_illegal = (dec_op == OP_ILLEGAL);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      capture   = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               capture = 1'b1;
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_pc       <= '0;
         out_op_q     <= OP_LUI;
         out_funct3   <= '0;
         out_funct7b5 <= 1'b0;
         out_rd       <= '0;
         out_imm      <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_illegal  <= 1'b0;
      end else if (capture) begin
         out_pc       <= in_pc;
         out_op_q     <= dec_op;
         out_funct3   <= in_ins[14:12];
         out_funct7b5 <= in_ins[30];
         out_rd       <= rd_idx;
         out_imm      <= imm_gen(in_ins, dec_fmt);
         out_rs1_data <= rs1_rd_data;
         out_rs2_data <= rs2_rd_data;
         out_illegal  <= dec_illegal;
      end
   end

   assign out_op = out_op_q;

endmodule

// File: tb/tb_idu_stage.sv
// Directed self-checking bench for idu_stage; follows IDU_RV32E_EN if defined.
module tb_idu_stage;
   import npc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_ins;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [3:0]  out_op;
   logic [2:0]  out_funct3;
   logic        out_funct7b5;
   logic [4:0]  out_rd;
   logic [31:0] out_imm;
   logic [31:0] out_rs1_data;
   logic [31:0] out_rs2_data;
   logic        out_illegal;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int unsigned checks = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   idu_stage #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_ins       (in_ins),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_op       (out_op),
      .out_funct3   (out_funct3),
      .out_funct7b5 (out_funct7b5),
      .out_rd       (out_rd),
      .out_imm      (out_imm),
      .out_rs1_data (out_rs1_data),
      .out_rs2_data (out_rs2_data),
      .out_illegal  (out_illegal),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction in IDLE for a single edge, leaving the packet held in FULL.
   task automatic send(input logic [31:0] pc, input logic [31:0] ins);
      in_valid = 1'b1;
      in_pc    = pc;
      in_ins   = ins;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_ins    = '0;
      out_ready = 1'b0;
      wb_en     = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      step();
      step();
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_op", {28'b0, out_op}, {28'b0, OP_LUI});
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_imm", out_imm, 32'd0);
      rst = 1'b0;
      step();

      // addi x1,x0,5
      send(32'h8000_0000, 32'h0050_0093);
      check("addi_valid", {31'b0, out_valid}, 32'd1);
      check("addi_in_ready", {31'b0, in_ready}, 32'd0);
      check("addi_op", {28'b0, out_op}, {28'b0, OP_OPIMM});
      check("addi_rd", {27'b0, out_rd}, 32'd1);
      check("addi_imm", out_imm, 32'd5);
      check("addi_rs1", out_rs1_data, 32'd0);
      check("addi_pc", out_pc, 32'h8000_0000);
      check("addi_illegal", {31'b0, out_illegal}, 32'd0);
      drain();
      check("addi_drained", {31'b0, out_valid}, 32'd0);

      // write x1, then add x3,x1,x2
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_1234;
      step();
      wb_en = 1'b0;
      send(32'h8000_0004, 32'h0020_81B3);
      check("add_op", {28'b0, out_op}, {28'b0, OP_OP});
      check("add_rs1", out_rs1_data, 32'h0000_1234);
      check("add_rs2", out_rs2_data, 32'd0);
      check("add_rd", {27'b0, out_rd}, 32'd3);
      check("add_imm", out_imm, 32'd0);
      // write to x1 while FULL must not disturb the held operand
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_5555;
      step();
      wb_en = 1'b0;
      check("full_write_stable", out_rs1_data, 32'h0000_1234);
      drain();

      // forward x2 in the capture cycle
      wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
      send(32'h8000_0008, 32'h0020_81B3);
      wb_en = 1'b0;
      check("fwd_rs2", out_rs2_data, 32'hDEAD_BEEF);
      check("fwd_rs1", out_rs1_data, 32'h0000_5555);

      // back-pressure: a new instruction offered while FULL must be ignored
      in_valid = 1'b1; in_pc = 32'h8000_000C; in_ins = 32'h0050_0093;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", {31'b0, out_valid}, 32'd1);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_rs2", out_rs2_data, 32'hDEAD_BEEF);
         check("bp_pc", out_pc, 32'h8000_0008);
      end
      in_valid = 1'b0;
      drain();
      check("bp_release", {31'b0, out_valid}, 32'd0);
      check("bp_release_ready", {31'b0, in_ready}, 32'd1);

      // x0 ignores writes
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
      step();
      wb_en = 1'b0;
      send(32'h8000_0010, 32'h0000_0013);
      check("x0_read", out_rs1_data, 32'd0);
      drain();

      // sw x2,8(x1)
      send(32'h8000_0014, 32'h0020_A423);
      check("sw_op", {28'b0, out_op}, {28'b0, OP_STORE});
      check("sw_imm", out_imm, 32'd8);
      check("sw_rs2", out_rs2_data, 32'hDEAD_BEEF);
      check("sw_funct3", {29'b0, out_funct3}, 32'd2);
      drain();

      // lui x1,0x12345
      send(32'h8000_0018, 32'h1234_50B7);
      check("lui_op", {28'b0, out_op}, {28'b0, OP_LUI});
      check("lui_imm", out_imm, 32'h1234_5000);
      drain();

      // beq x0,x0,-4
      send(32'h8000_001C, 32'hFE00_0EE3);
      check("beq_op", {28'b0, out_op}, {28'b0, OP_BRANCH});
      check("beq_imm", out_imm, 32'hFFFF_FFFC);
      check("beq_f7b5", {31'b0, out_funct7b5}, 32'd1);
      drain();

      // jal x0,0
      send(32'h8000_0020, 32'h0000_006F);
      check("jal_op", {28'b0, out_op}, {28'b0, OP_JAL});
      check("jal_imm", out_imm, 32'd0);
      drain();

      send(32'h8000_0024, 32'hFFFF_FFFF);
      check("ill_op", {28'b0, out_op}, {28'b0, OP_ILLEGAL});
      check("ill_flag", {31'b0, out_illegal}, 32'd1);
      check("ill_imm", out_imm, 32'd0);
      drain();

      // addi x16,x0,1
      send(32'h8000_0028, 32'h0010_0813);
      check("x16_op", {28'b0, out_op}, {28'b0, OP_OPIMM});
`ifdef IDU_RV32E_EN
      check("x16_illegal", {31'b0, out_illegal}, 32'd1);
`else
      check("x16_illegal", {31'b0, out_illegal}, 32'd0);
`endif
      drain();

      // asynchronous reset while FULL
      send(32'h8000_002C, 32'h0020_81B3);
      check("prerst_valid", {31'b0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", {31'b0, out_valid}, 32'd0);
      check("async_rst_pc", out_pc, 32'd0);
      step();
      rst = 1'b0;
      step();
      send(32'h8000_0030, 32'h0020_81B3);
      check("rst_clears_x1", out_rs1_data, 32'd0);
      check("rst_clears_x2", out_rs2_data, 32'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/idu_stage.md
# idu_stage

Decode stage of the multicycle NPC core, directly downstream of instruction fetch. It accepts one `{pc, instruction}` word per valid/ready handshake and decodes it as RV32I. It reads both source operands from an internal general-purpose register file and presents a registered decode packet to the execute stage through a second valid/ready handshake. It also owns the register-file write port, which is driven by write-back.

## Interface
Parameters:
- `WIDTH`, default 32: datapath and PC width.

Ports:
- `clk` (input, 1): single clock; all state updates on the rising edge.
- `rst` (input, 1): reset, asynchronous and active-high.
- `in_valid` (input, 1): fetch holds a valid instruction.
- `in_ready` (output, 1): decode can accept an instruction.
- `in_pc` (input, WIDTH): PC of the instruction.
- `in_ins` (input, 32): instruction word.
- `out_valid` (output, 1): decode packet valid.
- `out_ready` (input, 1): execute accepts the packet.
- `out_pc` (output, WIDTH): latched PC.
- `out_op` (output, 4): op class, an `op_e` value.
- `out_funct3` (output, 3): `ins[14:12]`.
- `out_funct7b5` (output, 1): `ins[30]`.
- `out_rd` (output, 5): destination register index.
- `out_imm` (output, 32): sign-extended immediate.
- `out_rs1_data` (output, 32): rs1 operand.
- `out_rs2_data` (output, 32): rs2 operand.
- `out_illegal` (output, 1): instruction not decodable.
- `wb_en` (input, 1): register-file write enable.
- `wb_rd` (input, 5): write index.
- `wb_data` (input, 32): write data.

## Operation
- Two-state FSM.
  - IDLE: `in_ready`=1, `out_valid`=0. When `in_valid` is high, capture the packet and go to FULL.
  - FULL: `in_ready`=0, `out_valid`=1. When `out_ready` is high, go to IDLE.
- Capture happens in one edge and decodes `in_ins` combinationally:
  - Latches `pc`, op class, funct fields, `rd` and `imm`.
  - Reads rs1 (`ins[19:15]`) and rs2 (`ins[24:20]`) from the register file.
- Op class is selected by `ins[6:0]`: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM. Any other opcode gives ILLEGAL with `out_illegal`=1. The packet is still delivered so that execute can trap.
- Immediates by format, each sign-extended from bit 31:
  - I: `ins[31:20]`.
  - S: `{ins[31:25], ins[11:7]}`.
  - B: `{ins[31], ins[7], ins[30:25], ins[11:8], 0}`.
  - U: `{ins[31:12], 12'b0}`.
  - J: `{ins[31], ins[19:12], ins[20], ins[30:21], 0}`.
  - R-type and ILLEGAL: 0.
- Register file: 32×32, two read ports, one write port.
  - x0 reads 0 and ignores writes.
  - A write takes effect at the edge where `wb_en`=1.
- Write-forward: if `wb_en`=1, `wb_rd`≠0 and `wb_rd` equals rs1 (or rs2) in the capture cycle, that operand takes `wb_data` rather than the stale array value.
- Register-file writes are accepted in every state, including FULL. Writes never alter an already-latched packet.

## Timing
- Reset state:
  - FSM in IDLE.
  - `in_ready`=1 and `out_valid`=0.
  - All `out_*` registers are 0, except `out_op`, which is LUI.
  - All registers in the register file are 0.
- Latency: the `in` handshake at edge N gives `out_valid`=1 after edge N; the packet is visible in cycle N+1.
- Throughput: one instruction per two cycles at best; there is no input/output overlap.
- `out_*` stay stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is a pure function of state; it never depends combinationally on `in_valid`.
- `out_valid` never depends on `out_ready`.
- Reset asserted mid-FULL drops the packet immediately; `out_valid` goes to 0 asynchronously.

## Configuration
- `IDU_RV32E_EN` defined:
  - The register file has 16 entries.
  - Any rs1, rs2 or rd index with bit 4 set forces `out_illegal`=1; the op class is unchanged.
  - Writes with `wb_rd[4]`=1 are ignored.
- `IDU_RV32E_EN` undefined: full 32-entry RV32I register file and no index check.

## Structure
- Package `npc_pkg` holds:
  - the `op_e` enum;
  - the 7-bit opcode constants;
  - the `imm_fmt_e` enum (I/S/B/U/J/NONE);
  - the `XLEN` constant.
- Sub-module `gpr_file` contains the register-file array, the x0 rule, the RV32E guard and the write-forward mux.
- Decode logic and the FSM live in `idu_stage`.

## Test plan
- **ADDI accepted:** after reset, send `in_ins`=0x00500093 (addi x1,x0,5) with `in_pc`=0x80000000 → next cycle `out_valid`=1, `out_op`=OPIMM, `out_rd`=1, `out_imm`=5, `out_rs1_data`=0.
- **Write-back then read:** `wb_en` with x1=0x1234, then send `in_ins`=0x002081B3 (add x3,x1,x2) → `out_rs1_data`=0x1234, `out_rs2_data`=0, `out_op`=OP.
- **Forward in capture cycle:** `wb_en`, `wb_rd`=2, `wb_data`=0xDEADBEEF in the same cycle as the handshake of an instruction with rs2=2 → `out_rs2_data`=0xDEADBEEF.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles → packet stable, `in_ready`=0, no new capture. Then raise `out_ready` → IDLE on the next edge.
- **Immediate decode:** send 0xFE000EE3 (beq x0,x0,-4) → BRANCH, `out_imm`=0xFFFFFFFC. Send 0x0000006F jal → JAL, `out_imm`=0. Send 0xFFFFFFFF → ILLEGAL with `out_illegal`=1.
- **Reset mid-FULL and RV32E:** assert `rst` while FULL → `out_valid`=0 without waiting for an edge. With `IDU_RV32E_EN` defined, an instruction with rd=x16 → `out_illegal`=1.
